// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: source tags and buffered result entries.
// Also holds the register-index width used across the pipe.
package wb_arbiter_pkg;

    localparam int REG_WIDTH = 5;
    localparam int WB_SRC_W  = 3;

    typedef enum logic [WB_SRC_W-1:0] {
        WB_SRC_NONE = 3'd0,
        WB_SRC_ALU  = 3'd1,
        WB_SRC_LSD  = 3'd2,
        WB_SRC_MUL  = 3'd3,
        WB_SRC_DIV  = 3'd4
    } wb_src_t;

    typedef struct packed {
        logic [REG_WIDTH-1:0] rd;
        logic [31:0]          data;
    } wb_arb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// EXE-to-writeback bus seen by the arbiter.
// master drives results, slave is the arbiter.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                 alu_valid;
    logic                 alu_wr_en;
    logic [REG_WIDTH-1:0] alu_rd;
    logic [31:0]          alu_data;

    logic                 lsd_valid;
    logic                 lsd_wr_en;
    logic [REG_WIDTH-1:0] lsd_rd;
    logic [31:0]          lsd_data;

    logic                 mul_valid;
    logic                 mul_ready;
    logic [REG_WIDTH-1:0] mul_rd;
    logic [31:0]          mul_data;

    logic                 div_valid;
    logic                 div_ready;
    logic [REG_WIDTH-1:0] div_rd;
    logic [31:0]          div_data;

    logic                 wb_wr_en;
    logic [REG_WIDTH-1:0] wb_rd;
    logic [31:0]          wb_wr_data;
    wb_src_t              wb_src;
    logic                 ix_hold;

    modport master (
        output alu_valid, alu_wr_en, alu_rd, alu_data,
        output lsd_valid, lsd_wr_en, lsd_rd, lsd_data,
        output mul_valid, mul_rd, mul_data,
        output div_valid, div_rd, div_data,
        input  mul_ready, div_ready,
        input  wb_wr_en, wb_rd, wb_wr_data, wb_src, ix_hold
    );

    modport slave (
        input  alu_valid, alu_wr_en, alu_rd, alu_data,
        input  lsd_valid, lsd_wr_en, lsd_rd, lsd_data,
        input  mul_valid, mul_rd, mul_data,
        input  div_valid, div_rd, div_data,
        output mul_ready, div_ready,
        output wb_wr_en, wb_rd, wb_wr_data, wb_src, ix_hold
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Small circular buffer for one variable-latency result stream.
// Head is registered storage; no push-to-head bypass.
module wb_result_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_arb_entry_t push_entry,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output wb_arb_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_result_fifo: DEPTH must be a power of two >= 2");
    end

    wb_arb_entry_t   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;

    assign full  = (occ == OW'(DEPTH));
    assign empty = (occ == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Flush is pointer-only; stale storage is never visible while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipe results first, MUL/DIV round-robin.
// Optional starvation guard enabled by WB_ARB_STARVE_GUARD_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT out of range");
    end

    wb_arb_entry_t        mul_in;
    wb_arb_entry_t        div_in;
    wb_arb_entry_t        mul_head;
    wb_arb_entry_t        div_head;
    logic                 mul_full;
    logic                 mul_empty;
    logic                 div_full;
    logic                 div_empty;
    logic                 mul_push;
    logic                 div_push;
    logic                 mul_pop;
    logic                 div_pop;
    logic                 granted;
    logic                 pipe_take;
    logic                 last_mul;
    wb_src_t              sel;

    logic                 wr_en_q;
    logic [REG_WIDTH-1:0] rd_q;
    logic [31:0]          data_q;
    wb_src_t              src_q;

    assign mul_in   = '{rd: bus.mul_rd, data: bus.mul_data};
    assign div_in   = '{rd: bus.div_rd, data: bus.div_data};
    assign mul_push = bus.mul_valid && !mul_full;
    assign div_push = bus.div_valid && !div_full;

    assign bus.mul_ready = !mul_full;
    assign bus.div_ready = !div_full;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (mul_push),
        .push_entry (mul_in),
        .pop        (mul_pop),
        .full       (mul_full),
        .empty      (mul_empty),
        .head       (mul_head)
    );

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_div_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (div_push),
        .push_entry (div_in),
        .pop        (div_pop),
        .full       (div_full),
        .empty      (div_empty),
        .head       (div_head)
    );

    assign pipe_take = bus.alu_valid || bus.lsd_valid;

    // MUL wins a tie unless it was the last one granted.
    always_comb begin
        sel = WB_SRC_NONE;
        if (bus.alu_valid) begin
            sel = WB_SRC_ALU;
        end else if (bus.lsd_valid) begin
            sel = WB_SRC_LSD;
        end else if (!mul_empty && (div_empty || !last_mul)) begin
            sel = WB_SRC_MUL;
        end else if (!div_empty) begin
            sel = WB_SRC_DIV;
        end
    end

    assign mul_pop = (sel == WB_SRC_MUL);
    assign div_pop = (sel == WB_SRC_DIV);
    assign granted = mul_pop || div_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q  <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            src_q    <= WB_SRC_NONE;
            last_mul <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            src_q   <= sel;
            unique case (sel)
                WB_SRC_ALU: begin
                    wr_en_q <= bus.alu_wr_en;
                    rd_q    <= bus.alu_rd;
                    data_q  <= bus.alu_data;
                end
                WB_SRC_LSD: begin
                    wr_en_q <= bus.lsd_wr_en;
                    rd_q    <= bus.lsd_rd;
                    data_q  <= bus.lsd_data;
                end
                WB_SRC_MUL: begin
                    wr_en_q <= 1'b1;
                    rd_q    <= mul_head.rd;
                    data_q  <= mul_head.data;
                end
                WB_SRC_DIV: begin
                    wr_en_q <= 1'b1;
                    rd_q    <= div_head.rd;
                    data_q  <= div_head.data;
                end
                default: ;
            endcase
            if (granted) begin
                last_mul <= mul_pop;
            end
        end
    end

    assign bus.wb_wr_en   = wr_en_q;
    assign bus.wb_rd      = rd_q;
    assign bus.wb_wr_data = data_q;
    assign bus.wb_src     = src_q;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end else begin
            if (granted || (mul_empty && div_empty)) begin
                starve_cnt <= '0;
            end else if (pipe_take && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            hold_q <= (starve_cnt == LIMIT);
        end
    end

    assign bus.ix_hold = hold_q;
`else
    assign bus.ix_hold = 1'b0;
`endif

    a_pipe_excl: assert property (
        @(posedge clk) disable iff (rst)
        !(bus.alu_valid && bus.lsd_valid)
    );

endmodule
